// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: PC control, redirect, imem and decode handshakes.
// master = fetch unit side, slave = PC/imem/decode environment side.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_in;
  logic            pc_enable;
  logic            pc_jump;
  logic [XLEN-1:0] pc_jump_addr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_fault;

  modport master (
    input  pc_in,
    input  redirect_valid,
    input  redirect_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  imem_rsp_err,
    input  inst_ready,
    output pc_enable,
    output pc_jump,
    output pc_jump_addr,
    output imem_req_valid,
    output imem_req_addr,
    output inst_valid,
    output inst_data,
    output inst_pc,
    output inst_fault
  );

  modport slave (
    output pc_in,
    output redirect_valid,
    output redirect_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output imem_rsp_err,
    output inst_ready,
    input  pc_enable,
    input  pc_jump,
    input  pc_jump_addr,
    input  imem_req_valid,
    input  imem_req_addr,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    input  inst_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem read, decode hand-off,
// PC advance/redirect control and wrong-path squashing.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] ipc_q;
  logic            fault_q;

  logic            live;
  logic            redir;
  logic            misaligned;
  logic            req_valid;
  logic            req_fire;
  logic            ld_req;
  logic            ld_inst;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] ld_pc;
  logic            ld_fault;

  // Bus outputs; reset forces every output low, even with a redirect pending.
  always_comb begin
    live       = !reset;
    redir      = live && bus.redirect_valid;
    misaligned = |bus.pc_in[1:0];
    req_valid  = live && (state_q == REQ)
                 && !redir && !misaligned;
    req_fire   = req_valid && bus.imem_req_ready;

    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = live ? bus.pc_in : '0;
    bus.pc_enable      = redir || req_fire;
    bus.pc_jump        = redir;
    bus.pc_jump_addr   = live ? bus.redirect_addr : '0;
    bus.inst_valid     = (state_q == HOLD) && !redir;
    bus.inst_data      = data_q;
    bus.inst_pc        = ipc_q;
    bus.inst_fault     = fault_q;
  end

  // Next state and register load controls; redirect overrides everything.
  always_comb begin
    state_d  = state_q;
    ld_req   = 1'b0;
    ld_inst  = 1'b0;
    ld_data  = NOP_INST;
    ld_pc    = bus.pc_in;
    ld_fault = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redir) begin
          state_d = REQ;
        end else if (misaligned) begin
          ld_inst  = 1'b1;
          ld_fault = 1'b1;
          state_d  = HOLD;
        end else if (req_fire) begin
          ld_req  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redir) begin
          state_d = bus.imem_rsp_valid ? REQ : DROP;
        end else if (bus.imem_rsp_valid) begin
          ld_inst  = 1'b1;
          ld_data  = bus.imem_rsp_err ? NOP_INST
                                      : bus.imem_rsp_data;
          ld_pc    = req_pc_q;
          ld_fault = bus.imem_rsp_err;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (redir || bus.inst_ready) state_d = REQ;
      end
      DROP: begin
        if (bus.imem_rsp_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request address and presented-instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pc_q <= '0;
      data_q   <= '0;
      ipc_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (ld_req) req_pc_q <= bus.pc_in;
      if (ld_inst) begin
        data_q  <= ld_data;
        ipc_q   <= ld_pc;
        fault_q <= ld_fault;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with PC register and imem models.
// Checks fetch order, stalls, redirects, faults and async reset.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  instr_fetch_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] pc_q;
  int          rsp_delay = 1;
  logic        force_en = 1'b0;
  logic [31:0] force_data = 32'h0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  int          cnt;
  logic [31:0] pend_data;
  logic        pend_err;
  int          en_cnt = 0;
  int          jmp_cnt = 0;
  int          req_cnt = 0;
  int          hs_cnt = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign bus.pc_in = pc_q;

  // PC register model, reset together with the fetch unit.
  always @(posedge clk or posedge reset) begin
    if (reset) pc_q <= 32'h0;
    else if (bus.pc_enable)
      pc_q <= bus.pc_jump ? bus.pc_jump_addr : pc_q + 32'd4;
  end

  // Instruction memory model: response rsp_delay cycles after accept.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= 32'h0;
      bus.imem_rsp_err   <= 1'b0;
      cnt                <= 0;
    end else begin
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_err   <= 1'b0;
      if (cnt == 1) begin
        bus.imem_rsp_valid <= 1'b1;
        bus.imem_rsp_data  <= pend_data;
        bus.imem_rsp_err   <= pend_err;
        cnt                <= 0;
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (rsp_delay == 1) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= force_en ? force_data
                                         : mem(bus.imem_req_addr);
          bus.imem_rsp_err   <= err_en
                                && bus.imem_req_addr == err_addr;
        end else begin
          cnt       <= rsp_delay - 1;
          pend_data <= force_en ? force_data
                                : mem(bus.imem_req_addr);
          pend_err  <= err_en && bus.imem_req_addr == err_addr;
        end
      end
    end
  end

  // Event counters for strobes and handshakes.
  always @(posedge clk) begin
    en_cnt  <= en_cnt + int'(bus.pc_enable);
    jmp_cnt <= jmp_cnt + int'(bus.pc_jump);
    req_cnt <= req_cnt
               + int'(bus.imem_req_valid && bus.imem_req_ready);
    hs_cnt  <= hs_cnt + int'(bus.inst_valid && bus.inst_ready);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_inst(input string tag,
                           input logic [31:0] epc,
                           input logic [31:0] edata,
                           input logic efault,
                           output int lat);
    @(negedge clk);
    lat = 1;
    while (!bus.inst_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
    chk({tag, "_pc"}, bus.inst_pc, epc);
    chk({tag, "_data"}, bus.inst_data, edata);
    chk({tag, "_fault"}, 32'(bus.inst_fault), 32'(efault));
  endtask

  int lat;
  int e0;
  int j0;
  int r0;
  int h0;

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_inst_fault", 32'(bus.inst_fault), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_pc_enable", 32'(bus.pc_enable), 32'd0);

    // 1: straight-line fetch 0, 4, 8
    e0 = en_cnt;
    j0 = jmp_cnt;
    reset = 1'b0;
    wait_inst("t1_i0", 32'h0, mem(32'h0), 1'b0, lat);
    chk("t1_latency0", 32'(lat), 32'd3);
    wait_inst("t1_i1", 32'h4, mem(32'h4), 1'b0, lat);
    chk("t1_latency1", 32'(lat), 32'd3);
    wait_inst("t1_i2", 32'h8, mem(32'h8), 1'b0, lat);
    chk("t1_en_pulses", 32'(en_cnt - e0), 32'd3);
    chk("t1_jump_pulses", 32'(jmp_cnt - j0), 32'd0);

    // 2: decode stall for 5 cycles in HOLD
    bus.inst_ready = 1'b0;
    e0 = en_cnt;
    r0 = req_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_valid", 32'(bus.inst_valid), 32'd1);
      chk("t2_pc", bus.inst_pc, 32'h8);
      chk("t2_data", bus.inst_data, mem(32'h8));
      chk("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("t2_pc_enable", 32'(bus.pc_enable), 32'd0);
    end
    chk("t2_en_pulses", 32'(en_cnt - e0), 32'd0);
    chk("t2_req_count", 32'(req_cnt - r0), 32'd0);
    chk("t2_pc_reg", pc_q, 32'hC);
    bus.inst_ready = 1'b1;

    // 3: redirect while WAIT, late response dropped
    @(negedge clk);
    rsp_delay  = 2;
    force_en   = 1'b1;
    force_data = 32'hDEAD_BEEF;
    @(negedge clk);
    j0 = jmp_cnt;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h100;
    #1;
    chk("t3_pc_jump", 32'(bus.pc_jump), 32'd1);
    chk("t3_pc_enable", 32'(bus.pc_enable), 32'd1);
    chk("t3_jump_addr", bus.pc_jump_addr, 32'h100);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    chk("t3_pc_jump_off", 32'(bus.pc_jump), 32'd0);
    chk("t3_pc_reg", pc_q, 32'h100);
    chk("t3_drop_req", 32'(bus.imem_req_valid), 32'd0);
    chk("t3_drop_valid", 32'(bus.inst_valid), 32'd0);
    rsp_delay = 1;
    force_en  = 1'b0;
    wait_inst("t3_i", 32'h100, mem(32'h100), 1'b0, lat);
    chk("t3_jump_pulses", 32'(jmp_cnt - j0), 32'd1);

    // 4: redirect in HOLD together with inst_ready
    wait_inst("t4_pre", 32'h104, mem(32'h104), 1'b0, lat);
    h0 = hs_cnt;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h40;
    #1;
    chk("t4_squash", 32'(bus.inst_valid), 32'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("t4_no_handshake", 32'(hs_cnt - h0), 32'd0);
    chk("t4_pc_reg", pc_q, 32'h40);
    wait_inst("t4_i", 32'h40, mem(32'h40), 1'b0, lat);

    // 5: misaligned redirect target, then bus error
    @(negedge clk);
    r0 = req_cnt;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h102;
    #1;
    chk("t5_req_blocked", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5_mis_req", 32'(bus.imem_req_valid), 32'd0);
    chk("t5_mis_en", 32'(bus.pc_enable), 32'd0);
    wait_inst("t5_mis", 32'h102, 32'h0000_0013, 1'b1, lat);
    chk("t5_req_count", 32'(req_cnt - r0), 32'd0);
    chk("t5_pc_hold", pc_q, 32'h102);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h8;
    err_en   = 1'b1;
    err_addr = 32'h8;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_inst("t5_err", 32'h8, 32'h0000_0013, 1'b1, lat);
    err_en = 1'b0;
    wait_inst("t5_ok", 32'hC, mem(32'hC), 1'b0, lat);

    // 6: asynchronous reset while WAIT
    rsp_delay = 3;
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_wait", 32'(bus.imem_req_valid), 32'd0);
    reset = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h200;
    #1;
    chk("t6_inst_data", bus.inst_data, 32'h0);
    chk("t6_inst_pc", bus.inst_pc, 32'h0);
    chk("t6_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_pc_enable", 32'(bus.pc_enable), 32'd0);
    chk("t6_pc_jump", 32'(bus.pc_jump), 32'd0);
    chk("t6_req_addr", bus.imem_req_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    rsp_delay = 1;
    reset = 1'b0;
    wait_inst("t6_i", 32'h0, mem(32'h0), 1'b0, lat);
    chk("t6_latency", 32'(lat), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
